// File: rtl/dmem_pkg.sv
// Shared types and constants for the memory-stage responder.
// Holds the FSM state encoding and the wait-counter width.
// No logic of its own.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    // Wide enough for WAIT_CYCLES up to 15.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word-addressed data storage: one synchronous write port, one registered read port.
// Latency: writes land on the enabling edge; read data is valid the cycle after rd_vld.
// No backpressure: the caller never asserts rd_vld and wr_vld together.
module dmem_array #(
    parameter int WORD_LEN = 8,
    parameter int DEPTH    = 64,
    parameter int IDX_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic [IDX_W-1:0]    idx,
    input  logic                wr_vld,
    input  logic [WORD_LEN-1:0] wr_dat,
    input  logic                rd_vld,
    output logic [WORD_LEN-1:0] rd_dat
);

    logic [WORD_LEN-1:0] mem [DEPTH];
    logic [WORD_LEN-1:0] rd_dat_q;
    logic [WORD_LEN-1:0] rd_dat_d;

    // Storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[idx] <= wr_dat;
        end
    end

    // Read port captures a new word only when asked, otherwise holds.
    always_comb begin
        rd_dat_d = rd_dat_q;
        if (rd_vld) begin
            rd_dat_d = mem[idx];
        end
    end

    // Read data register.
    always_ff @(posedge clk) begin
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/data_mem_responder.sv
// MEM-stage load/store responder over a multi-cycle data array.
// Latency: WAIT_CYCLES+1 stalled cycles per request, then one RESP cycle with registered strobes.
// Backpressure: stall holds EX/MEM and earlier stages; inputs are only sampled in IDLE.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int WORD_LEN    = 8,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [WORD_LEN-1:0] addr,
    input  logic [WORD_LEN-1:0] wdata,
    output logic                stall,
    output logic [WORD_LEN-1:0] rdata,
    output logic                rdata_valid,
    output logic                addr_err
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] CNT_INIT = WAIT_CNT_W'(WAIT_CYCLES - 1);

    mem_state_t            state_q, state_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                  is_wr_q, is_wr_d;
    logic [WORD_LEN-1:0]   addr_q, addr_d;
    logic [WORD_LEN-1:0]   wdata_q, wdata_d;
    logic [WORD_LEN-1:0]   rdata_q, rdata_d;
    logic                  rvld_q, rvld_d;
    logic                  aerr_q, aerr_d;

    logic                  stall_c;
    logic                  arr_we;
    logic                  arr_re;
    logic [WORD_LEN-1:0]   arr_rdata;
    logic                  out_of_range;

    // Any address bit above the index field means the word does not exist;
    // such accesses never touch the array rather than aliasing onto a low index.
    assign out_of_range = |(addr_q >> IDX_W);

    // Next-state, latch and array-control logic; request fields are captured only in IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        rvld_d  = 1'b0;
        aerr_d  = 1'b0;
        stall_c = 1'b0;
        arr_we  = 1'b0;
        arr_re  = 1'b0;

        case (state_q)
            IDLE: begin
                stall_c = mem_read | mem_write;
                if (mem_read | mem_write) begin
                    // A simultaneous read+write is a store.
                    is_wr_d = mem_write;
                    addr_d  = addr;
                    wdata_d = wdata;
                    cnt_d   = CNT_INIT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                stall_c = 1'b1;
                if (cnt_q == '0) begin
                    arr_we  = is_wr_q & ~out_of_range;
                    arr_re  = ~is_wr_q & ~out_of_range;
                    rvld_d  = ~is_wr_q;
                    aerr_d  = out_of_range;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                // Only a completing load refreshes rdata; out-of-range loads return zero.
                if (rvld_q) begin
                    rdata_d = aerr_q ? '0 : arr_rdata;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and latched-request registers; reset aborts any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            is_wr_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rvld_q  <= 1'b0;
            aerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            is_wr_q <= is_wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            rvld_q  <= rvld_d;
            aerr_q  <= aerr_d;
        end
    end

    dmem_array #(
        .WORD_LEN (WORD_LEN),
        .DEPTH    (DEPTH),
        .IDX_W    (IDX_W)
    ) u_array (
        .clk    (clk),
        .idx    (addr_q[IDX_W-1:0]),
        .wr_vld (arr_we),
        .wr_dat (wdata_q),
        .rd_vld (arr_re),
        .rd_dat (arr_rdata)
    );

    // Stall is suppressed while reset is held so the pipeline is not frozen by a dying request.
    assign stall       = stall_c & ~rst;
    assign rdata       = rdata_d;
    assign rdata_valid = rvld_q;
    assign addr_err    = aerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_read;
    logic       mem_write;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       stall;
    logic [7:0] rdata;
    logic       rdata_valid;
    logic       addr_err;

    int n_pass  = 0;
    int n_total = 0;

    data_mem_responder #(
        .WORD_LEN    (8),
        .DEPTH       (64),
        .WAIT_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .addr_err    (addr_err)
    );

    always #5 clk = ~clk;

    // rdata_valid pulse counter, sampled on the falling edge.
    logic pulse_en = 1'b0;
    int   pulses   = 0;
    always @(negedge clk) begin
        if (pulse_en && rdata_valid) pulses++;
    end

    typedef struct {
        logic       rd;
        logic       wr;
        logic [7:0] a;
        logic [7:0] d;
        logic [7:0] er;   // expected rdata in RESP and held afterwards
        logic       ev;   // expected rdata_valid in RESP
        logic       ee;   // expected addr_err in RESP
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] a,
                                input logic [7:0] d, input logic [7:0] er,
                                input logic ev, input logic ee);
        vec_t v;
        v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.er = er; v.ev = ev; v.ee = ee;
        return v;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // Presents one request from IDLE, holds it while stalled, checks RESP, then drops it.
    task automatic access(input logic rd, input logic wr, input logic [7:0] a,
                          input logic [7:0] d, input logic [7:0] er,
                          input logic ev, input logic ee, input string nm);
        int n;
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = d;
        #1;
        n = 0;
        while (stall && n < 20) begin
            n++;
            @(posedge clk);
            #1;
        end
        check({nm, " stall_cycles"}, n, 3);
        check({nm, " resp_stall"}, int'(stall), 0);
        check({nm, " rdata_valid"}, int'(rdata_valid), int'(ev));
        check({nm, " addr_err"}, int'(addr_err), int'(ee));
        check({nm, " rdata"}, int'(rdata), int'(er));
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        #1;
        check({nm, " idle_valid"}, int'(rdata_valid), 0);
        check({nm, " idle_err"}, int'(addr_err), 0);
        check({nm, " idle_rdata_hold"}, int'(rdata), int'(er));
    endtask

    initial begin
        int exp_pulses;

        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;

        //            rd    wr    addr   wdata  exp_rd ev    ee
        vecs[0]  = mk(1'b0, 1'b1, 8'h05, 8'hA5, 8'h00, 1'b0, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, 8'h05, 8'h00, 8'hA5, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 1'b1, 8'h06, 8'h5A, 8'hA5, 1'b0, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, 8'h46, 8'h00, 8'h00, 1'b1, 1'b1);
        vecs[4]  = mk(1'b0, 1'b1, 8'h46, 8'h11, 8'h00, 1'b0, 1'b1);
        vecs[5]  = mk(1'b1, 1'b0, 8'h06, 8'h00, 8'h5A, 1'b1, 1'b0);
        vecs[6]  = mk(1'b1, 1'b1, 8'h10, 8'h3C, 8'h5A, 1'b0, 1'b0);
        vecs[7]  = mk(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b1, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 8'h3F, 8'hE7, 8'h3C, 1'b0, 1'b0);
        vecs[9]  = mk(1'b1, 1'b0, 8'h3F, 8'h00, 8'hE7, 1'b1, 1'b0);
        vecs[10] = mk(1'b1, 1'b0, 8'h40, 8'h00, 8'h00, 1'b1, 1'b1);
        vecs[11] = mk(1'b0, 1'b1, 8'h01, 8'hC1, 8'h00, 1'b0, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 8'h02, 8'hC2, 8'h00, 1'b0, 1'b0);
        vecs[13] = mk(1'b1, 1'b0, 8'h01, 8'h00, 8'hC1, 1'b1, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 8'h02, 8'h00, 8'hC2, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 1'b1, 8'h08, 8'h99, 8'hC2, 1'b0, 1'b0);
        vecs[16] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);

        // Reset state, during and after reset.
        repeat (2) @(posedge clk);
        #1;
        check("rst stall", int'(stall), 0);
        check("rst rdata", int'(rdata), 0);
        check("rst valid", int'(rdata_valid), 0);
        check("rst err", int'(addr_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst stall", int'(stall), 0);
        check("post_rst rdata", int'(rdata), 0);
        check("post_rst valid", int'(rdata_valid), 0);

        // Table: every request follows its predecessor's RESP directly.
        exp_pulses = 0;
        pulse_en   = 1'b1;
        for (int i = 0; i < 17; i++) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d,
                   vecs[i].er, vecs[i].ev, vecs[i].ee, $sformatf("v%0d", i));
            if (vecs[i].ev) exp_pulses++;
        end
        pulse_en = 1'b0;
        check("valid_pulse_count", pulses, exp_pulses);

        // Inputs change during WAIT and RESP: latched load of 0x05 must complete unchanged.
        mem_read = 1'b1; mem_write = 1'b0; addr = 8'h05; wdata = 8'h00;
        #1;
        check("chg idle_stall", int'(stall), 1);
        @(posedge clk);
        #1;
        mem_read = 1'b0; mem_write = 1'b1; addr = 8'h10; wdata = 8'hEE;
        #1;
        check("chg wait1_stall", int'(stall), 1);
        @(posedge clk);
        #1;
        addr = 8'h3F;
        #1;
        check("chg wait0_stall", int'(stall), 1);
        @(posedge clk);
        #1;
        check("chg resp_stall", int'(stall), 0);
        check("chg resp_valid", int'(rdata_valid), 1);
        check("chg resp_err", int'(addr_err), 0);
        check("chg resp_rdata", int'(rdata), 8'hA5);
        // A new request shown in RESP must not be taken until IDLE.
        mem_read = 1'b1; mem_write = 1'b0; addr = 8'h01;
        #1;
        check("chg resp_ignore_stall", int'(stall), 0);
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 8'h01, 8'h00, 8'hC1, 1'b1, 1'b0, "after_resp_req");
        access(1'b1, 1'b0, 8'h10, 8'h00, 8'h3C, 1'b1, 1'b0, "chg rb10");
        access(1'b1, 1'b0, 8'h3F, 8'h00, 8'hE7, 1'b1, 1'b0, "chg rb3f");

        // Reset in the second WAIT cycle of a store of 0x77 to 0x08.
        mem_read = 1'b0; mem_write = 1'b1; addr = 8'h08; wdata = 8'h77;
        #1;
        check("abort idle_stall", int'(stall), 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("abort wait2_stall", int'(stall), 1);
        rst = 1'b1;
        #1;
        check("abort rst_stall", int'(stall), 0);
        check("abort rst_rdata", int'(rdata), 0);
        check("abort rst_valid", int'(rdata_valid), 0);
        check("abort rst_err", int'(addr_err), 0);
        @(posedge clk);
        #1;
        check("abort rst_hold_valid", int'(rdata_valid), 0);
        mem_write = 1'b0;
        rst = 1'b0;
        #1;
        check("abort idle_no_stall", int'(stall), 0);
        access(1'b1, 1'b0, 8'h08, 8'h00, 8'h99, 1'b1, 1'b0, "abort rb08");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
